ascon_aead_sequencer: RTL and testbench

Host-side initiator for the single-block ASCON AEAD engine. It accepts encrypt/decrypt requests on a valid/ready port and manages the nonce counter for encryption. It drives the engine's enable, start, key, nonce and data pins, detects completion or timeout, and returns ciphertext, tag or plaintext plus status on a valid/ready response port. Plaintext from a failed decryption is never released.

---
 rtl/ascon_pkg.sv | 24 ++
 rtl/ascon_nonce_ctr.sv | 25 ++
 rtl/ascon_aead_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_ascon_aead_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types and constants for the ASCON AEAD sequencer
// Contents: sequencer state enum, response status enum, ASCON constants.
package ascon_pkg;

    localparam logic [63:0] ASCON_IV    = 64'h80400c0600000000;
    localparam int          ASCON_TAG_W = 128;
    localparam int          ASCON_BLK_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_RELEASE,
        S_RESP
    } seq_state_t;

    typedef enum logic [1:0] {
        ST_OK              = 2'd0,
        ST_AUTH_FAIL       = 2'd1,
        ST_TIMEOUT         = 2'd2,
        ST_NONCE_EXHAUSTED = 2'd3
    } ascon_status_t;

endpackage

// File: rtl/ascon_nonce_ctr.sv
// rtl/ascon_nonce_ctr.sv - saturating encryption nonce counter
// Ports: clk, rst (sync active-low), inc (advance request),
//        count (current value), exhausted (count is all-ones).
module ascon_nonce_ctr #(
    parameter int CTR_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CTR_W-1:0] count,
    output logic             exhausted
);

    // All-ones is terminal: only reset leaves it, so a nonce is never reused.
    assign exhausted = &count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !exhausted) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ascon_aead_sequencer.sv
// rtl/ascon_aead_sequencer.sv - host-side request sequencer for the single-block ASCON AEAD engine
// Ports: req_* request handshake and payload, key / nonce_prefix static inputs,
//        rsp_* response handshake and payload, busy, core_* engine control and data pins.
module ascon_aead_sequencer
    import ascon_pkg::*;
#(
    parameter int MSG_LAT = 24,
    parameter int TIMEOUT = 64,
    parameter int CTR_W   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [ASCON_BLK_W-1:0] req_data,
    input  logic [ASCON_TAG_W-1:0] req_tag,
    input  logic [127:0]           req_nonce,
    input  logic [127:0]           key,
    input  logic [63:0]            nonce_prefix,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ASCON_BLK_W-1:0] rsp_data,
    output logic [ASCON_TAG_W-1:0] rsp_tag,
    output logic [127:0]           rsp_nonce,
    output logic [1:0]             rsp_status,
    output logic                   busy,
    output logic                   core_rst,
    output logic                   core_en,
    output logic                   core_enc_start,
    output logic                   core_dec_start,
    output logic [127:0]           core_key,
    output logic [127:0]           core_nonce,
    output logic [ASCON_BLK_W-1:0] core_pt,
    output logic [159:0]           core_ct,
    input  logic [ASCON_BLK_W-1:0] core_msg,
    input  logic [ASCON_TAG_W-1:0] core_tag,
    input  logic                   core_enc_done,
    input  logic                   core_auth_done,
    input  logic                   core_dec_fail
);

    localparam int CNT_W = 16;

    seq_state_t               state, state_next;
    ascon_status_t            status_q;
    logic                     op_q;
    logic [ASCON_BLK_W-1:0]   data_q;
    logic [ASCON_TAG_W-1:0]   tag_q;
    logic [127:0]             nonce_q;
    logic [CNT_W-1:0]         cyc_q;
    logic [CNT_W-1:0]         elapsed;
    logic [CTR_W-1:0]         ctr;
    logic [63:0]              ctr_ext;
    logic                     exhausted;
    logic                     ctr_inc;
    logic                     done_hit;
    logic                     timeout_hit;
    logic                     msg_hit;

    ascon_nonce_ctr #(.CTR_W(CTR_W)) u_nonce_ctr (
        .clk       (clk),
        .rst       (rst),
        .inc       (ctr_inc),
        .count     (ctr),
        .exhausted (exhausted)
    );

    assign ctr_ext = 64'(ctr);

    // cyc_q is cleared in START, so elapsed is the number of cycles since the
    // start-pulse cycle; it equals the engine's own step count in RUN.
    assign elapsed     = cyc_q + 1'b1;
    assign done_hit    = (state == S_RUN) && (op_q ? core_auth_done : core_enc_done);
    assign timeout_hit = (state == S_RUN) && !done_hit && (elapsed == CNT_W'(TIMEOUT));
    assign msg_hit     = (state == S_RUN) && (elapsed == CNT_W'(MSG_LAT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        busy           = 1'b0;
        rsp_valid      = 1'b0;
        core_rst       = 1'b0;
        core_en        = 1'b0;
        core_enc_start = 1'b0;
        core_dec_start = 1'b0;
        ctr_inc        = 1'b0;
        if (!rst) begin
            // Any pending response is dropped and the engine is held in reset.
            core_rst   = 1'b1;
            state_next = S_IDLE;
        end else begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        state_next = (!req_op && exhausted) ? S_RESP : S_START;
                    end
                end
                S_START: begin
                    core_en        = 1'b1;
                    core_enc_start = !op_q;
                    core_dec_start = op_q;
                    state_next     = S_RUN;
                end
                S_RUN: begin
                    core_en  = 1'b1;
                    core_rst = timeout_hit;
                    ctr_inc  = done_hit && !op_q;
                    if (done_hit || timeout_hit) begin
                        state_next = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // core_en low for this cycle clears the sticky authentication_done.
                    state_next = S_RESP;
                end
                S_RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q     <= 1'b0;
            data_q   <= '0;
            tag_q    <= '0;
            nonce_q  <= '0;
            cyc_q    <= '0;
            status_q <= ST_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        data_q   <= req_data;
                        tag_q    <= req_tag;
                        status_q <= ST_OK;
                        nonce_q  <= req_op ? req_nonce : {nonce_prefix, ctr_ext};
                        if (!req_op && exhausted) begin
                            data_q   <= '0;
                            tag_q    <= '0;
                            status_q <= ST_NONCE_EXHAUSTED;
                        end
                    end
                end
                S_START: begin
                    cyc_q <= '0;
                end
                S_RUN: begin
                    cyc_q <= elapsed;
                    if (msg_hit) begin
                        data_q <= core_msg;
                    end
                    if (done_hit) begin
                        if (!op_q) begin
                            tag_q    <= core_tag;
                            status_q <= ST_OK;
                        end else begin
                            tag_q <= '0;
                            if (core_dec_fail) begin
                                // Unauthenticated plaintext must never leave the block.
                                status_q <= ST_AUTH_FAIL;
                                data_q   <= '0;
                            end else begin
                                status_q <= ST_OK;
                            end
                        end
                    end else if (timeout_hit) begin
                        status_q <= ST_TIMEOUT;
                        data_q   <= '0;
                        tag_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_key   = key;
    assign core_nonce = nonce_q;
    assign core_pt    = data_q;
    // The engine compares the tag low word first, hence the swapped halves.
    assign core_ct    = {data_q, tag_q[63:0], tag_q[127:64]};

    assign rsp_data   = rsp_valid ? data_q : '0;
    assign rsp_tag    = rsp_valid ? tag_q : '0;
    assign rsp_nonce  = rsp_valid ? nonce_q : '0;
    assign rsp_status = rsp_valid ? status_q : 2'd0;

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// tb/tb_ascon_aead_sequencer.sv - self-checking bench for ascon_aead_sequencer with a behavioural engine stub
module tb_ascon_aead_sequencer;

    localparam int MSG_LAT = 24;
    localparam int TIMEOUT = 64;
    localparam int CTR_MAX = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_op;
    logic [31:0]  req_data;
    logic [127:0] req_tag, req_nonce, key;
    logic [63:0]  pfx;
    logic         rsp_valid, rsp_ready;
    logic [31:0]  rsp_data;
    logic [127:0] rsp_tag, rsp_nonce;
    logic [1:0]   rsp_status;
    logic         busy, core_rst, core_en, core_enc_start, core_dec_start;
    logic [127:0] core_key, core_nonce;
    logic [31:0]  core_pt, core_msg;
    logic [159:0] core_ct;
    logic [127:0] core_tag;
    logic         core_enc_done, core_auth_done, core_dec_fail;

    always #5 clk = ~clk;

    ascon_aead_sequencer #(.MSG_LAT(MSG_LAT), .TIMEOUT(TIMEOUT), .CTR_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_tag(req_tag), .req_nonce(req_nonce),
        .key(key), .nonce_prefix(pfx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_nonce(rsp_nonce), .rsp_status(rsp_status),
        .busy(busy), .core_rst(core_rst), .core_en(core_en),
        .core_enc_start(core_enc_start), .core_dec_start(core_dec_start),
        .core_key(core_key), .core_nonce(core_nonce), .core_pt(core_pt),
        .core_ct(core_ct), .core_msg(core_msg), .core_tag(core_tag),
        .core_enc_done(core_enc_done), .core_auth_done(core_auth_done),
        .core_dec_fail(core_dec_fail)
    );

    // Toy engine transform: keystream word and tag derived from key, nonce, plaintext.
    function automatic logic [31:0] mask_fn(input logic [127:0] k, input logic [127:0] n);
        return k[31:0] ^ n[31:0] ^ n[95:64] ^ 32'h9E3779B9;
    endfunction

    function automatic logic [127:0] tag_fn(input logic [127:0] k, input logic [127:0] n,
                                            input logic [31:0] p);
        return {k[127:64] ^ n[63:0], k[63:0] ^ n[127:64]} ^ {4{p}}
               ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine stub controls
    bit st_hang = 0, st_glitch = 0;
    int st_lat = 30;

    logic         eng_busy = 0, eng_op = 0;
    int           eng_t = 0;
    logic [127:0] eng_key = 0, eng_nonce = 0;
    logic [31:0]  eng_pt = 0, noise = 0;
    logic [159:0] eng_ct = 0;

    always @(posedge clk) begin
        noise <= $urandom;
        if (core_rst) begin
            eng_busy <= 1'b0;
            eng_t    <= 0;
        end else if (core_en && (core_enc_start || core_dec_start)) begin
            eng_busy  <= 1'b1;
            eng_t     <= 1;
            eng_op    <= core_dec_start;
            eng_key   <= core_key;
            eng_nonce <= core_nonce;
            eng_pt    <= core_pt;
            eng_ct    <= core_ct;
        end else if (!core_en) begin
            eng_busy <= 1'b0;
            eng_t    <= 0;
        end else if (eng_busy) begin
            eng_t <= eng_t + 1;
        end
    end

    logic [31:0] eng_msg, eng_plain;
    logic        eng_fin;
    always_comb begin
        eng_msg   = (eng_op ? eng_ct[159:128] : eng_pt) ^ mask_fn(eng_key, eng_nonce);
        eng_plain = eng_op ? eng_msg : eng_pt;
        eng_fin   = eng_busy && !st_hang && (eng_t >= st_lat);
        core_msg  = (eng_busy && eng_t == MSG_LAT) ? eng_msg : noise;
        core_tag  = eng_fin ? tag_fn(eng_key, eng_nonce, eng_plain) : {4{noise}};
        core_enc_done  = (eng_fin && !eng_op) || (st_glitch && core_en && core_enc_start);
        core_auth_done = (eng_fin && eng_op) || (st_glitch && core_en && core_dec_start);
        core_dec_fail  = eng_fin && eng_op &&
                         ({eng_ct[63:0], eng_ct[127:64]} != tag_fn(eng_key, eng_nonce, eng_plain));
    end

    // Pin-level monitor
    int   n_en = 0, n_start = 0, n_crst = 0, n_viol = 0, last_evt = -100, zero_run = 2;
    logic prev_start = 0, prev_en = 0, prev_evt = 0;
    always @(negedge clk) begin
        logic s, ev;
        s  = core_enc_start | core_dec_start;
        ev = rst && ((core_en && !s && (core_enc_done || core_auth_done)) || core_rst);
        if (rst) begin
            if (core_en)                        n_en++;
            if (s)                              n_start++;
            if (core_rst)                       n_crst++;
            if (s && !core_en)                  n_viol++;
            if (s && prev_start)                n_viol++;
            if (core_en && !prev_en && zero_run < 2) n_viol++;
        end
        if (ev && !prev_evt) last_evt = cyc;
        zero_run   = core_en ? 0 : zero_run + 1;
        prev_start = s;
        prev_en    = core_en;
        prev_evt   = ev;
    end

    int n_tests = 0, n_fail = 0;
    int m_ctr = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input bit op, input logic [31:0] d, input logic [127:0] t,
                         input logic [127:0] n, input bit hang, input int lat,
                         input bit glitch, input int hold);
        logic [31:0]  e_data, pt;
        logic [127:0] e_tag, e_nonce;
        logic [1:0]   e_st;
        logic [289:0] snap;
        bit           engine, stable;
        int           en0, st0, rs0, w;
        engine = 1;
        if (!op) begin
            e_nonce = {pfx, 64'(m_ctr)};
            if (m_ctr == CTR_MAX) begin
                engine = 0; e_st = 2'd3; e_data = 0; e_tag = 0;
            end else if (hang) begin
                e_st = 2'd2; e_data = 0; e_tag = 0;
            end else begin
                e_st = 2'd0; e_data = d ^ mask_fn(key, e_nonce); e_tag = tag_fn(key, e_nonce, d);
                m_ctr++;
            end
        end else begin
            e_nonce = n; e_tag = 0;
            pt = d ^ mask_fn(key, n);
            if (hang)                         begin e_st = 2'd2; e_data = 0;  end
            else if (t == tag_fn(key, n, pt)) begin e_st = 2'd0; e_data = pt; end
            else                              begin e_st = 2'd1; e_data = 0;  end
        end
        st_hang = hang; st_lat = lat; st_glitch = glitch;

        w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        check("req_ready_idle", req_ready, 1'b1);
        if (!req_ready) return;
        en0 = n_en; st0 = n_start; rs0 = n_crst;
        req_valid = 1; req_op = op; req_data = d; req_tag = t; req_nonce = n;
        @(posedge clk); #1;
        req_valid = 0; req_op = $urandom; req_data = $urandom;
        req_tag = {4{$urandom}}; req_nonce = {4{$urandom}};
        check("req_ready_fall", req_ready, 1'b0);

        w = 0;
        while (!rsp_valid && w < 200) begin @(posedge clk); #1; w++; end
        check("rsp_valid_seen", rsp_valid, 1'b1);
        if (!rsp_valid) return;
        if (engine) begin
            check("done_to_valid", cyc - last_evt, 2);
        end else begin
            check("exh_no_en", n_en - en0, 0);
            check("exh_no_start", n_start - st0, 0);
        end
        check("rsp_status", rsp_status, e_st);
        check("rsp_data", rsp_data, e_data);
        check("rsp_tag", rsp_tag, e_tag);
        check("rsp_nonce", rsp_nonce, e_nonce);
        check("core_rst_pulses", n_crst - rs0, (hang && engine) ? 1 : 0);

        snap = {rsp_data, rsp_tag, rsp_nonce, rsp_status};
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || {rsp_data, rsp_tag, rsp_nonce, rsp_status} != snap)
                stable = 0;
        end
        if (hold > 0) check("rsp_hold_stable", stable, 1'b1);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("rsp_drop", {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    task automatic mid_reset();
        int w;
        bit quiet;
        key = {4{$urandom}};
        st_hang = 0; st_lat = 60; st_glitch = 0;
        w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        req_valid = 1; req_op = 1; req_data = $urandom;
        req_tag = {4{$urandom}}; req_nonce = {4{$urandom}};
        @(posedge clk); #1;
        req_valid = 0;
        w = 0;
        while (!(core_en && !core_dec_start) && w < 10) begin @(posedge clk); #1; w++; end
        check("mid_reset_in_run", core_en && !core_dec_start, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst = 0; #1;
        check("mid_reset_active", {core_rst, core_en, rsp_valid, req_ready}, 4'b1000);
        @(posedge clk); #1;
        rst = 1; #1;
        check("mid_reset_ctl", {req_ready, busy, rsp_valid, core_en, core_enc_start,
                                core_dec_start, core_rst}, 7'b1000000);
        check("mid_reset_rsp", {rsp_data, rsp_tag, rsp_status}, 0);
        m_ctr = 0;
        quiet = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid || busy || core_en) quiet = 0;
        end
        check("mid_reset_no_rsp", quiet, 1'b1);
    endtask

    initial begin
        logic [31:0]  d, p;
        logic [127:0] n, t;
        int           r, lat;
        rst = 0; req_valid = 0; req_op = 0; req_data = 0; req_tag = 0; req_nonce = 0;
        key = 0; pfx = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {req_ready, busy, rsp_valid, core_en, core_enc_start,
                            core_dec_start, core_rst}, 7'b0000001);
        check("reset_rsp", {rsp_data, rsp_tag, rsp_status}, 0);
        rst = 1; #1;
        check("post_reset_ctl", {req_ready, busy, rsp_valid, core_en, core_enc_start,
                                 core_dec_start, core_rst}, 7'b1000000);

        // Zero key/prefix/data encrypt, then a second one using counter 1.
        do_op(0, 32'h0, 0, 0, 0, 30, 0, 0);
        do_op(0, 32'h0, 0, 0, 0, 30, 0, 0);
        // Decrypt of the first ciphertext, then with tag bit 0 flipped.
        d = mask_fn(128'h0, 128'h0);
        t = tag_fn(128'h0, 128'h0, 32'h0);
        do_op(1, d, t, 128'h0, 0, 30, 0, 0);
        do_op(1, d, t ^ 128'h1, 128'h0, 0, 30, 0, 0);
        // Engine that never completes, then a normal request.
        do_op(0, $urandom, 0, 0, 1, 30, 0, 0);
        do_op(0, $urandom, 0, 0, 0, TIMEOUT, 1, 0);
        // Response back-pressure for 10 cycles.
        do_op(1, $urandom, {4{$urandom}}, {4{$urandom}}, 0, MSG_LAT, 0, 10);

        for (int i = 0; i < 50; i++) begin
            if (i == 30) mid_reset();
            key = {4{$urandom}};
            pfx = {$urandom, $urandom};
            r = $urandom_range(0, 3);
            lat = (r == 0) ? MSG_LAT : (r == 1) ? TIMEOUT : $urandom_range(MSG_LAT + 1, TIMEOUT - 1);
            if ($urandom_range(0, 1) == 0) begin
                do_op(0, $urandom, 0, 0, ($urandom_range(0, 7) == 0), lat,
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            end else begin
                n = {4{$urandom}};
                p = $urandom;
                t = tag_fn(key, n, p);
                if ($urandom_range(0, 1) == 0) t = t ^ (128'h1 << $urandom_range(0, 127));
                do_op(1, p ^ mask_fn(key, n), t, n, ($urandom_range(0, 7) == 0), lat,
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            end
        end

        check("protocol_violations", n_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
